// File: rtl/sigmoid_pipe_fix.sv
// sigmoid_pipe_fix: 3-stage multi-lane fixed-point sigmoid.
// Per-beat mode: MSB truncation or rounded PLAN approximation.
module sigmoid_pipe_fix #(
  parameter int WIDTH_IN = 8,
  parameter int FRAC_IN  = 4,
  parameter int MSB_OUT  = 4,
  parameter int LANES    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [LANES*WIDTH_IN-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*MSB_OUT-1:0]    out_data,
  output logic [LANES-1:0]            out_sat,
  output logic [15:0]                 beat_cnt
);

  localparam int FI = FRAC_IN + 5;
  localparam int AW = WIDTH_IN + 1;
  localparam int YW = FI + 2;
  localparam int SH = FI - MSB_OUT;

  localparam logic [YW-1:0] ONE  = YW'(1) << FI;
  localparam logic [YW-1:0] OFF2 = YW'(27) << FRAC_IN;
  localparam logic [YW-1:0] OFF1 = YW'(5) << (FI - 3);
  localparam logic [YW-1:0] OFF0 = YW'(1) << (FI - 1);
  localparam logic [YW:0]   HALF = (YW+1)'(1) << (SH - 1);
  localparam logic [YW:0]   RMAX = (YW+1)'(1) << MSB_OUT;

  localparam logic [AW-1:0] T3 = AW'(5) << FRAC_IN;
  localparam logic [AW-1:0] T2 = AW'(19) << (FRAC_IN - 3);
  localparam logic [AW-1:0] T1 = AW'(1) << FRAC_IN;

  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  logic                            s1_mode;
  logic [LANES-1:0]                s1_neg;
  logic [LANES-1:0][AW-1:0]        s1_a;
  logic [LANES-1:0][1:0]           s1_seg;
  logic [LANES-1:0][MSB_OUT-1:0]   s1_msb;

  logic                            s2_mode;
  logic [LANES-1:0]                s2_neg;
  logic [LANES-1:0][YW-1:0]        s2_y;
  logic [LANES-1:0][MSB_OUT-1:0]   s2_msb;

  logic [LANES-1:0]                n1_neg;
  logic [LANES-1:0][AW-1:0]        n1_a;
  logic [LANES-1:0][1:0]           n1_seg;
  logic [LANES-1:0][MSB_OUT-1:0]   n1_msb;
  logic [LANES-1:0][WIDTH_IN-1:0]  x;
  logic [LANES-1:0][AW-1:0]        xs;

  logic [LANES-1:0][YW-1:0]        n2_y;

  logic [LANES-1:0][YW-1:0]        yp;
  logic [LANES-1:0][YW:0]          rr;
  logic [LANES*MSB_OUT-1:0]        n3_d;
  logic [LANES-1:0]                n3_s;

  assign rdy3      = !v3 | out_ready;
  assign rdy2      = !v2 | rdy3;
  assign rdy1      = !v1 | rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v3;

  // S1 comb: sign, magnitude in AW bits, segment select
  always_comb begin
    n1_neg = '0;
    n1_a   = '0;
    n1_seg = '0;
    n1_msb = '0;
    x      = '0;
    xs     = '0;
    for (int i = 0; i < LANES; i++) begin
      x[i]      = in_data[i*WIDTH_IN +: WIDTH_IN];
      xs[i]     = {x[i][WIDTH_IN-1], x[i]};
      n1_neg[i] = x[i][WIDTH_IN-1];
      n1_a[i]   = n1_neg[i] ? (~xs[i] + AW'(1)) : xs[i];
      n1_msb[i] = x[i][WIDTH_IN-1 -: MSB_OUT];
      unique case (1'b1)
        (n1_a[i] >= T3):                  n1_seg[i] = 2'd3;
        (n1_a[i] >= T2 && n1_a[i] < T3):  n1_seg[i] = 2'd2;
        (n1_a[i] >= T1 && n1_a[i] < T2):  n1_seg[i] = 2'd1;
        (n1_a[i] < T1):                   n1_seg[i] = 2'd0;
      endcase
    end
  end

  // S2 comb: slope-shift plus offset for the chosen segment
  always_comb begin
    n2_y = '0;
    for (int i = 0; i < LANES; i++) begin
      unique case (s1_seg[i])
        2'd3: n2_y[i] = ONE;
        2'd2: n2_y[i] = YW'(s1_a[i]) + OFF2;
        2'd1: n2_y[i] = (YW'(s1_a[i]) << 2) + OFF1;
        2'd0: n2_y[i] = (YW'(s1_a[i]) << 3) + OFF0;
      endcase
    end
  end

  // S3 comb: mirror negatives, round half-up, clamp
  always_comb begin
    yp   = '0;
    rr   = '0;
    n3_d = '0;
    n3_s = '0;
    for (int i = 0; i < LANES; i++) begin
      yp[i] = s2_neg[i] ? (ONE - s2_y[i]) : s2_y[i];
      rr[i] = ({1'b0, yp[i]} + HALF) >> SH;
      if (!s2_mode) begin
        n3_d[i*MSB_OUT +: MSB_OUT] = s2_msb[i];
      end else if (rr[i] >= RMAX) begin
        n3_d[i*MSB_OUT +: MSB_OUT] = '1;
        n3_s[i] = 1'b1;
      end else begin
        n3_d[i*MSB_OUT +: MSB_OUT] = rr[i][MSB_OUT-1:0];
        n3_s[i] = (rr[i] == '0) && (s2_y[i] != '0);
      end
    end
  end

  // stage valid bits; each stage loads whenever it may advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (rdy1) v1 <= in_valid;
      if (rdy2) v2 <= v1;
      if (rdy3) v3 <= v2;
    end
  end

  // S1/S2 datapath registers, loaded only with a real beat
  always_ff @(posedge clk) begin
    if (rdy1 && in_valid) begin
      s1_mode <= in_mode;
      s1_neg  <= n1_neg;
      s1_a    <= n1_a;
      s1_seg  <= n1_seg;
      s1_msb  <= n1_msb;
    end
    if (rdy2 && v1) begin
      s2_mode <= s1_mode;
      s2_neg  <= s1_neg;
      s2_y    <= n2_y;
      s2_msb  <= s1_msb;
    end
  end

  // output registers hold while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sat  <= '0;
    end else if (rdy3 && v2) begin
      out_data <= n3_d;
      out_sat  <= n3_s;
    end
  end

  // completed output handshakes, free-running wrap
  always_ff @(posedge clk) begin
    if (!rst_n) beat_cnt <= '0;
    else if (v3 && out_ready) beat_cnt <= beat_cnt + 16'd1;
  end

endmodule

// File: tb/tb_sigmoid_pipe_fix.sv
// tb_sigmoid_pipe_fix: directed table, stall, reset, wrap
// and randomized beats against a real-valued sigmoid model.
module tb_sigmoid_pipe_fix;

  logic        clk = 0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_sat;
  logic [15:0] beat_cnt;

  sigmoid_pipe_fix dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] din;
    logic [15:0] dexp;
    logic [3:0]  sexp;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  s;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic [15:0] cnt_m = 0;
  bit   hold = 0;
  logic [15:0] hold_d;
  logic [3:0]  hold_s;
  bit   saw_block;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] lane_model(input logic mode,
                                            input logic [7:0] x);
    real xr, a, y, yc;
    int  r;
    if (!mode) return {1'b0, x[7:4]};
    xr = $itor($signed(x)) / 16.0;
    a  = (xr < 0.0) ? -xr : xr;
    if (a >= 5.0)        y = 1.0;
    else if (a >= 2.375) y = a / 32.0 + 0.84375;
    else if (a >= 1.0)   y = a / 8.0 + 0.625;
    else                 y = a / 4.0 + 0.5;
    yc = (xr < 0.0) ? 1.0 - y : y;
    r  = int'($floor(yc * 16.0 + 0.5));
    if (r >= 16) return {1'b1, 4'hF};
    if (r == 0 && y != 0.0) return {1'b1, 4'h0};
    return {1'b0, 4'(r)};
  endfunction

  function automatic exp_t beat_model(input logic mode,
                                      input logic [31:0] din);
    exp_t e;
    logic [4:0] l;
    for (int i = 0; i < 4; i++) begin
      l = lane_model(mode, din[i*8 +: 8]);
      e.d[i*4 +: 4] = l[3:0];
      e.s[i] = l[4];
    end
    return e;
  endfunction

  // scoreboard: order, data, stall stability, beat count
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
      hold  = 0;
    end else begin
      chk("beat_cnt", beat_cnt, cnt_m);
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_d);
        chk("stall_sat", out_sat, hold_s);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got %0h want none", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_sat", out_sat, e.s);
        end
        cnt_m = cnt_m + 16'd1;
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      hold_s = out_sat;
      if (in_valid && in_ready)
        q.push_back(beat_model(in_mode, in_data));
    end
  end

  vec_t tv[7];

  task automatic send_one(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1; in_mode = v.mode; in_data = v.din; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("lat_early", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("tbl_data", out_data, v.dexp);
    chk("tbl_sat", out_sat, v.sexp);
  endtask

  task automatic drain();
    int c = 0;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    while (q.size() != 0 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic stream(input int n, input int slo, input int shi,
                        input bit rnd);
    int  sent = 0;
    int  c = 0;
    bit  have = 0;
    saw_block = 0;
    while (sent < n && c < n * 10 + 50) begin
      @(posedge clk); #1;
      out_ready = rnd ? ($urandom_range(3) != 0) : !(c >= slo && c <= shi);
      if (!have && (!rnd || $urandom_range(1) == 1)) begin
        have = 1;
        in_mode = 1'($urandom);
        in_data = $urandom;
      end
      in_valid = have;
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1;
      if (in_valid && in_ready) begin
        sent++;
        have = 0;
      end
      c++;
    end
    if (sent < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d want %0d", sent, n);
    end
    drain();
  endtask

  initial begin
    tv[0] = '{1'b1, 32'h08F01000, 16'hA4C8, 4'b0000};
    tv[1] = '{1'b1, 32'h2650807F, 16'hFF0F, 4'b0111};
    tv[2] = '{1'b0, 32'h007FA510, 16'h07A1, 4'b0000};
    tv[3] = '{1'b1, 32'hF1254F0F, 16'h4FFC, 4'b0010};
    tv[4] = '{1'b1, 32'h01D9E0B0, 16'h8120, 4'b0001};
    tv[5] = '{1'b0, 32'hC33CFF80, 16'hC3F8, 4'b0000};
    tv[6] = '{1'b1, 32'hE84030C0, 16'h3FF1, 4'b0100};

    rst_n = 0; in_valid = 0; in_mode = 0; in_data = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_cnt", beat_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_inready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      send_one(tv[i]);
      if (i == 0) begin
        @(posedge clk);
        @(negedge clk);
        chk("first_cnt", beat_cnt, 1);
      end
    end
    drain();

    stream(8, 1, 0, 0);
    stream(20, 5, 9, 0);
    chk("stall_inready_low", saw_block, 1);
    stream(300, 1, 0, 1);

    @(posedge clk); #1;
    in_valid = 1; in_mode = 1; in_data = $urandom; out_ready = 1;
    @(posedge clk); #1;
    in_data = $urandom; in_mode = 0;
    @(posedge clk); #1;
    in_valid = 0;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", beat_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midrst_quiet", out_valid, 0);
    chk("midrst_cnt2", beat_cnt, 0);

    stream(65535, 1, 0, 0);
    chk("wrap_ffff", beat_cnt, 16'hFFFF);
    stream(1, 1, 0, 0);
    chk("wrap_zero", beat_cnt, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
